abh: RTL and testbench

ABH -- requirements
Module: abh

---
 rtl/abh.sv | 152 +++++++++++++++
 tb/tb_abh.sv | 139 +++++++++++++
 2 files changed

// File: rtl/abh.sv
// abh -- address-bus-high stage of an 8-bit CPU address path.
//
// Selects the next high address byte (ADH) from the current high byte (ABH),
// the program counter high (PCH), the address hold (AHH), the data bus or a
// fixed page, then registers it into ABH.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   CI      carry from the address-low stage
//   pcl_co  carry out of the PCL increment
//   DB      data bus
//   op      high-byte operation select
//   ld_ahh  load AHH from DB
//   ld_pc   load PCH with ABH + pcl_co
//   ADH     unregistered next address-bus-high
//   PCH     program counter high (registered)
//   AHH     address hold high (registered)
//   fix     stall request, high during a carry-fixup cycle
//
// Build option: ABH_DEFER_CARRY_EN
//   defined   - a nonzero page-crossing adjustment (ops 0110/0111/1000) is
//               deferred to a one-cycle FIX state, like NMOS parts
//   undefined - the adjustment is applied in the same cycle, fix is tied 0
module abh (
  input  logic       clk,
  input  logic       rst,
  input  logic       CI,
  input  logic       pcl_co,
  input  logic [7:0] DB,
  input  logic [3:0] op,
  input  logic       ld_ahh,
  input  logic       ld_pc,
  output logic [7:0] ADH,
  output logic [7:0] PCH,
  output logic [7:0] AHH,
  output logic       fix
);

  logic [7:0] abh_q, abh_d;
  logic [7:0] pch_q, pch_d;
  logic [7:0] ahh_q, ahh_d;

  // Decode: adh_now is the full same-cycle result; adh_base/adj_* split the
  // carry-adjusting ops into base plus a +1/-1 adjustment for deferral.
  logic [7:0] adh_now, adh_base;
  logic       defer_op, adj_nz, adj_neg;

  always_comb begin
    adh_now  = abh_q;
    adh_base = abh_q;
    defer_op = 1'b0;
    adj_nz   = 1'b0;
    adj_neg  = 1'b0;
    unique case (op)
      4'b0000: adh_now = abh_q;
      4'b0001: adh_now = abh_q + {7'b0, CI};
      4'b0010: adh_now = pch_q;
      4'b0011: adh_now = 8'h01;
      4'b0100: adh_now = 8'h00;
      4'b0101: adh_now = 8'hFF;
      4'b0110: begin
        adh_now  = ahh_q + {7'b0, CI};
        adh_base = ahh_q;
        defer_op = 1'b1;
        adj_nz   = CI;
      end
      4'b0111: begin
        adh_now  = DB + {7'b0, CI};
        adh_base = DB;
        defer_op = 1'b1;
        adj_nz   = CI;
      end
      4'b1000: begin
        // Sign byte plus carry nets to -1, 0 or +1: nonzero only when they differ.
        adh_now  = abh_q + {8{DB[7]}} + {7'b0, CI};
        adh_base = abh_q;
        defer_op = 1'b1;
        adj_nz   = CI ^ DB[7];
        adj_neg  = DB[7];
      end
      default: adh_now = abh_q;
    endcase
  end

`ifdef ABH_DEFER_CARRY_EN
  typedef enum logic {IDLE = 1'b0, FIX = 1'b1} state_t;

  state_t state_q, state_d;
  logic   adj_neg_q, adj_neg_d;
  logic   ld_en;

  always_comb begin
    state_d   = state_q;
    adj_neg_d = adj_neg_q;
    ADH       = adh_now;
    fix       = 1'b0;
    ld_en     = 1'b1;
    if (state_q == FIX) begin
      // Dummy cycle: apply the latched adjustment whatever op says.
      ADH     = abh_q + (adj_neg_q ? 8'hFF : 8'h01);
      fix     = 1'b1;
      ld_en   = 1'b0;
      state_d = IDLE;
    end else if (defer_op && adj_nz) begin
      ADH       = adh_base;
      state_d   = FIX;
      adj_neg_d = adj_neg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      adj_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adj_neg_q <= adj_neg_d;
    end
  end
`else
  logic ld_en;

  always_comb begin
    ADH   = adh_now;
    fix   = 1'b0;
    ld_en = 1'b1;
  end
`endif

  always_comb begin
    abh_d = ADH;
    ahh_d = (ld_ahh && ld_en) ? DB : ahh_q;
    pch_d = (ld_pc && ld_en) ? (abh_q + {7'b0, pcl_co}) : pch_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      abh_q <= 8'h00;
      pch_q <= 8'h00;
      ahh_q <= 8'h00;
    end else begin
      abh_q <= abh_d;
      pch_q <= pch_d;
      ahh_q <= ahh_d;
    end
  end

  assign PCH = pch_q;
  assign AHH = ahh_q;

endmodule

// File: tb/tb_abh.sv
// Directed-vector bench for abh. Each vector's hand-computed expectation is
// queued when the vector is driven; a negedge monitor pops and compares.
module tb_abh;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       CI = 1'b0, pcl_co = 1'b0, ld_ahh = 1'b0, ld_pc = 1'b0;
  logic [7:0] DB = 8'h00;
  logic [3:0] op = 4'h0;
  logic [7:0] ADH, PCH, AHH;
  logic       fix;

  abh dut (
    .clk(clk), .rst(rst), .CI(CI), .pcl_co(pcl_co), .DB(DB), .op(op),
    .ld_ahh(ld_ahh), .ld_pc(ld_pc), .ADH(ADH), .PCH(PCH), .AHH(AHH), .fix(fix)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] adh, pch, ahh;
    logic       fix;
    bit         chk_reg;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Monitor: every cycle presents an output, compare against the queue head.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (ADH !== e.adh) begin
        n_bad++;
        $display("FAIL %s ADH got %h want %h", e.name, ADH, e.adh);
      end
      if (e.chk_reg) begin
        if (PCH !== e.pch || AHH !== e.ahh || fix !== e.fix) begin
          n_bad++;
          $display("FAIL %s PCH/AHH/fix got %h/%h/%b want %h/%h/%b",
                   e.name, PCH, AHH, fix, e.pch, e.ahh, e.fix);
        end
      end
    end
  end

  task automatic s(input string n, input logic r, input logic [3:0] o,
                   input logic c, input logic [7:0] d, input logic la,
                   input logic lp, input logic pc, input logic [7:0] ea,
                   input logic ef, input logic [7:0] ep, input logic [7:0] eh,
                   input bit cr);
    exp_t e;
    rst = r; op = o; CI = c; DB = d; ld_ahh = la; ld_pc = lp; pcl_co = pc;
    e.name = n; e.adh = ea; e.fix = ef; e.pch = ep; e.ahh = eh; e.chk_reg = cr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    //  name         rst op   CI DB    la lp pc  ADH   fix PCH   AHH  chk
    s("rst_adh",     1, 4'h3, 0, 8'h00, 0, 0, 0, 8'h01, 0, 8'h00, 8'h00, 0);
    s("post_rst",    0, 4'h0, 0, 8'h12, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1);
    s("ahh_ci0",     0, 4'h6, 0, 8'h00, 0, 0, 0, 8'h12, 0, 8'h00, 8'h12, 1);
    s("abh_12",      0, 4'h0, 0, 8'h00, 0, 0, 0, 8'h12, 0, 8'h00, 8'h12, 1);
`ifdef ABH_DEFER_CARRY_EN
    s("ahh_ci1",     0, 4'h6, 1, 8'h00, 0, 0, 0, 8'h12, 0, 8'h00, 8'h12, 1);
    s("ahh_fix",     0, 4'h0, 0, 8'h00, 0, 0, 0, 8'h13, 1, 8'h00, 8'h12, 1);
`else
    s("ahh_ci1",     0, 4'h6, 1, 8'h00, 0, 0, 0, 8'h13, 0, 8'h00, 8'h12, 1);
`endif
    s("abh_13",      0, 4'h0, 0, 8'h00, 0, 0, 0, 8'h13, 0, 8'h00, 8'h12, 1);
    s("vec_page",    0, 4'h5, 0, 8'h00, 0, 0, 0, 8'hFF, 0, 8'h00, 8'h12, 1);
    s("ldpc_co0",    0, 4'h0, 0, 8'h00, 0, 1, 0, 8'hFF, 0, 8'h00, 8'h12, 1);
    s("ldpc_co1",    0, 4'h0, 0, 8'h00, 0, 1, 1, 8'hFF, 0, 8'hFF, 8'h12, 1);
    s("pch_wrap",    0, 4'h2, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'h12, 1);
    s("abh_inc",     0, 4'h1, 1, 8'h00, 0, 0, 0, 8'h01, 0, 8'h00, 8'h12, 1);
`ifdef ABH_DEFER_CARRY_EN
    s("db_ci1",      0, 4'h7, 1, 8'h7F, 0, 0, 0, 8'h7F, 0, 8'h00, 8'h12, 1);
    s("db_fix",      0, 4'h0, 0, 8'h00, 0, 0, 0, 8'h80, 1, 8'h00, 8'h12, 1);
`else
    s("db_ci1",      0, 4'h7, 1, 8'h7F, 0, 0, 0, 8'h80, 0, 8'h00, 8'h12, 1);
`endif
    s("stack_page",  0, 4'h3, 0, 8'h00, 0, 0, 0, 8'h01, 0, 8'h00, 8'h12, 1);
    s("zero_page",   0, 4'h4, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'h12, 1);
    s("db_ci0",      0, 4'h7, 0, 8'h20, 0, 0, 0, 8'h20, 0, 8'h00, 8'h12, 1);
`ifdef ABH_DEFER_CARRY_EN
    s("br_back",     0, 4'h8, 0, 8'hF0, 0, 0, 0, 8'h20, 0, 8'h00, 8'h12, 1);
    s("br_back_fix", 0, 4'h0, 0, 8'h00, 0, 0, 0, 8'h1F, 1, 8'h00, 8'h12, 1);
`else
    s("br_back",     0, 4'h8, 0, 8'hF0, 0, 0, 0, 8'h1F, 0, 8'h00, 8'h12, 1);
`endif
    s("db_20",       0, 4'h7, 0, 8'h20, 0, 0, 0, 8'h20, 0, 8'h00, 8'h12, 1);
    s("br_same",     0, 4'h8, 1, 8'hF0, 0, 0, 0, 8'h20, 0, 8'h00, 8'h12, 1);
    s("br_no_fix",   0, 4'h0, 0, 8'h00, 0, 0, 0, 8'h20, 0, 8'h00, 8'h12, 1);
`ifdef ABH_DEFER_CARRY_EN
    s("br_fwd",      0, 4'h8, 1, 8'h05, 0, 0, 0, 8'h20, 0, 8'h00, 8'h12, 1);
    s("br_fwd_fix",  0, 4'h0, 0, 8'h00, 0, 0, 0, 8'h21, 1, 8'h00, 8'h12, 1);
`else
    s("br_fwd",      0, 4'h8, 1, 8'h05, 0, 0, 0, 8'h21, 0, 8'h00, 8'h12, 1);
`endif
    s("both_ld",     0, 4'h9, 0, 8'hAB, 1, 1, 1, 8'h21, 0, 8'h00, 8'h12, 1);
    s("both_chk",    0, 4'hF, 0, 8'h00, 0, 0, 0, 8'h21, 0, 8'h22, 8'hAB, 1);
`ifdef ABH_DEFER_CARRY_EN
    s("fix_entry",   0, 4'h6, 1, 8'h00, 0, 0, 0, 8'hAB, 0, 8'h22, 8'hAB, 1);
    s("fix_ign_ld",  0, 4'h6, 1, 8'h55, 1, 1, 1, 8'hAC, 1, 8'h22, 8'hAB, 1);
    s("after_fix",   0, 4'h0, 0, 8'h00, 0, 0, 0, 8'hAC, 0, 8'h22, 8'hAB, 1);
    s("fix_entry2",  0, 4'h7, 1, 8'h10, 0, 0, 0, 8'h10, 0, 8'h22, 8'hAB, 1);
    s("rst_in_fix",  1, 4'h0, 0, 8'h00, 1, 1, 1, 8'h11, 1, 8'h22, 8'hAB, 1);
    s("rst_abort",   0, 4'h0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1);
`else
    s("rst_mid",     1, 4'h5, 0, 8'h00, 1, 1, 1, 8'hFF, 0, 8'h22, 8'hAB, 1);
    s("rst_after",   0, 4'h0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1);
`endif
    // Drain: the monitor must have consumed every queued expectation.
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain queue size %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout queue size %0d want 0", exp_q.size());
    $fatal(1, "timeout");
  end

endmodule
